vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT_PORCH, default 16; H_SYNC_PULSE, default 96; H_BACK_PORCH, default 48 (pixel clocks).
REQ-003 SHALL have parameter V_PIXELS, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FRONT_PORCH, default 10; V_SYNC_PULSE, default 2; V_BACK_PORCH, default 33 (lines).
REQ-005 SHALL have parameter SYNC_ACTIVE_LOW, default 1, sync polarity (1 = pulse drives 0).
REQ-006 SHALL have parameter LEAD, default 1, range 0..3: cycles by which coordinates precede the sync/de outputs.
REQ-007 clk  input  1  pixel clock.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 pixel_x  output  clog2(H_TOTAL)  horizontal coordinate, H_TOTAL = sum of H parameters.
REQ-010 pixel_y  output  clog2(V_TOTAL)  vertical coordinate, V_TOTAL = sum of V parameters.
REQ-011 line_start  output  1  pulse, pixel_x == 0.
REQ-012 frame_start  output  1  pulse, pixel_x == 0 and pixel_y == 0.
REQ-013 frame_count  output  8  frames completed, modulo 256.
REQ-014 de  output  1  display enable, delayed LEAD cycles.
REQ-015 hsync, vsync  output  1 each  sync outputs, delayed LEAD cycles, polarity per SYNC_ACTIVE_LOW.

Function
REQ-016 pixel_x SHALL increment by 1 each clock; at H_TOTAL-1 it SHALL wrap to 0 next clock.
REQ-017 pixel_y SHALL increment by 1 only on the pixel_x wrap; at V_TOTAL-1 coincident with the pixel_x wrap, both SHALL go to 0.
REQ-018 frame_count SHALL increment on the (H_TOTAL-1, V_TOTAL-1) -> (0,0) transition, wrapping 255 -> 0.
REQ-019 All outputs SHALL be registered; line_start, frame_start and frame_count SHALL be cycle-aligned with pixel_x/pixel_y.
REQ-020 Undelayed de_raw SHALL be true iff pixel_x < H_PIXELS and pixel_y < V_PIXELS.
REQ-021 Undelayed hsync pulse SHALL be active iff H_PIXELS+H_FRONT_PORCH <= pixel_x < H_PIXELS+H_FRONT_PORCH+H_SYNC_PULSE.
REQ-022 Undelayed vsync pulse SHALL be active iff V_PIXELS+V_FRONT_PORCH <= pixel_y < V_PIXELS+V_FRONT_PORCH+V_SYNC_PULSE, for whole lines (transitions at pixel_x == 0).
REQ-023 de, hsync, vsync SHALL equal the undelayed values from exactly LEAD clocks earlier; LEAD = 0 means same cycle as coordinates.
REQ-024 Delay-line stages SHALL be loaded with inactive values (de=0, syncs inactive) at reset, so the first LEAD cycles after reset show inactive outputs.
REQ-025 Elaboration SHALL fail if LEAD > 3 or any timing parameter is 0.

Reset
REQ-026 While rst_n = 0: pixel_x = 0, pixel_y = 0, frame_count = 0, line_start = 0, frame_start = 0, de = 0, hsync = vsync = inactive level.
REQ-027 First clock after rst_n rises SHALL present pixel_x = 0, pixel_y = 0, line_start = 1, frame_start = 1.
REQ-028 Reset asserted mid-frame SHALL take effect on the next clock edge with no completion of the current line or frame.

Structure
REQ-029 Shared package vga_pkg SHALL hold the 640x480@60 default timing constants and derived H_TOTAL/V_TOTAL localparams, reused by the graphics stage.
REQ-030 One sub-module, vga_delay_line (parameterised width and depth 0..3, resettable to a given value), SHALL implement REQ-023/024.

Verification
REQ-031 Reset release, defaults -> cycle 1: (0,0), line_start = 1, frame_start = 1; de = 0 (LEAD stage), de = 1 on cycle 2.
REQ-032 Defaults, run one line -> hsync low for exactly 96 clocks, falling edge LEAD = 1 clock after pixel_x == 656; line_start period 800 clocks.
REQ-033 Defaults, run one frame -> vsync low for exactly 2 x 800 clocks starting at line 490 (+1 clock); frame_start period 420000 clocks; frame_count = 1.
REQ-034 Force 256 frame wraps (small parameters, e.g. 4+1+1+1 / 3+1+1+1) -> frame_count reaches 255 then 0.
REQ-035 Assert rst_n = 0 at (400, 300) for 3 clocks -> all outputs at reset values during reset; restart per REQ-027.
REQ-036 LEAD = 0 and LEAD = 3 builds -> de rising edge coincides with, respectively trails by 3 clocks, pixel_x == 0 on line 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and control-signal types used by the
// timing generator and the downstream graphics stage.
package vga_pkg;

   localparam int unsigned H_PIXELS_DEF      = 640;
   localparam int unsigned H_FRONT_PORCH_DEF = 16;
   localparam int unsigned H_SYNC_PULSE_DEF  = 96;
   localparam int unsigned H_BACK_PORCH_DEF  = 48;
   localparam int unsigned V_PIXELS_DEF      = 480;
   localparam int unsigned V_FRONT_PORCH_DEF = 10;
   localparam int unsigned V_SYNC_PULSE_DEF  = 2;
   localparam int unsigned V_BACK_PORCH_DEF  = 33;

   localparam int unsigned H_TOTAL_DEF = H_PIXELS_DEF + H_FRONT_PORCH_DEF +
                                         H_SYNC_PULSE_DEF + H_BACK_PORCH_DEF;
   localparam int unsigned V_TOTAL_DEF = V_PIXELS_DEF + V_FRONT_PORCH_DEF +
                                         V_SYNC_PULSE_DEF + V_BACK_PORCH_DEF;

   // Sync fields carry the pin level, i.e. polarity is already applied.
   typedef struct packed {
      logic vsync;
      logic hsync;
      logic de;
   } vga_ctl_t;

   function automatic vga_ctl_t ctl_idle(bit sync_active_low);
      vga_ctl_t c;
      c.de    = 1'b0;
      c.hsync = sync_active_low;
      c.vsync = sync_active_low;
      return c;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline (0..3 stages) with a synchronous reset value;
// depth 0 is a plain wire.
module vga_delay_line #(
   parameter int unsigned     Width  = 1,
   parameter int unsigned     Depth  = 1,
   parameter logic [Width-1:0] RstVal = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   if (Depth > 3) begin : g_bad_depth
      $error("vga_delay_line: Depth must be 0..3");
   end

   if (Depth == 0) begin : g_bypass
      assign q_o = d_i;
   end else begin : g_pipe
      logic [Width-1:0] stage_q [Depth];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) stage_q[i] <= RstVal;
         end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q_o = stage_q[Depth-1];
   end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: registered pixel coordinates with line/frame
// strobes, and de/hsync/vsync trailing the coordinates by LEAD clocks.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_PIXELS        = H_PIXELS_DEF,
   parameter int unsigned H_FRONT_PORCH   = H_FRONT_PORCH_DEF,
   parameter int unsigned H_SYNC_PULSE    = H_SYNC_PULSE_DEF,
   parameter int unsigned H_BACK_PORCH    = H_BACK_PORCH_DEF,
   parameter int unsigned V_PIXELS        = V_PIXELS_DEF,
   parameter int unsigned V_FRONT_PORCH   = V_FRONT_PORCH_DEF,
   parameter int unsigned V_SYNC_PULSE    = V_SYNC_PULSE_DEF,
   parameter int unsigned V_BACK_PORCH    = V_BACK_PORCH_DEF,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1,
   parameter int unsigned LEAD            = 1,
   localparam int unsigned H_TOTAL = H_PIXELS + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
   localparam int unsigned V_TOTAL = V_PIXELS + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
   localparam int unsigned HW      = $clog2(H_TOTAL),
   localparam int unsigned VW      = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [HW-1:0] pixel_x_o,
   output logic [VW-1:0] pixel_y_o,
   output logic          line_start_o,
   output logic          frame_start_o,
   output logic [7:0]    frame_count_o,
   output logic          de_o,
   output logic          hsync_o,
   output logic          vsync_o
);

   if (LEAD > 3 || H_PIXELS == 0 || H_FRONT_PORCH == 0 || H_SYNC_PULSE == 0 ||
       H_BACK_PORCH == 0 || V_PIXELS == 0 || V_FRONT_PORCH == 0 || V_SYNC_PULSE == 0 ||
       V_BACK_PORCH == 0) begin : g_bad_param
      $error("vga_timing: LEAD must be 0..3 and every timing parameter non-zero");
   end

   localparam logic [HW-1:0] XLast   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] XVis    = HW'(H_PIXELS);
   localparam logic [HW-1:0] HsStart = HW'(H_PIXELS + H_FRONT_PORCH);
   localparam logic [HW-1:0] HsEnd   = HW'(H_PIXELS + H_FRONT_PORCH + H_SYNC_PULSE);
   localparam logic [VW-1:0] YLast   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] YVis    = VW'(V_PIXELS);
   localparam logic [VW-1:0] VsStart = VW'(V_PIXELS + V_FRONT_PORCH);
   localparam logic [VW-1:0] VsEnd   = VW'(V_PIXELS + V_FRONT_PORCH + V_SYNC_PULSE);

   logic [HW-1:0] x_q, x_d;
   logic [VW-1:0] y_q, y_d;
   logic [7:0]    frame_count_q, frame_count_d;
   logic          run_q;
   logic          line_start_q, frame_start_q;
   vga_ctl_t      ctl_q, ctl_d, ctl_dly;

   // run_q holds the raster at (0,0) for the first clock after reset so that
   // cycle presents the origin with its strobes.
   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      frame_count_d = frame_count_q;
      if (run_q) begin
         if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) begin
               y_d           = '0;
               frame_count_d = frame_count_q + 8'd1;
            end else begin
               y_d = y_q + VW'(1);
            end
         end else begin
            x_d = x_q + HW'(1);
         end
      end
      ctl_d.de    = (x_d < XVis) && (y_d < YVis);
      ctl_d.hsync = ((x_d >= HsStart) && (x_d < HsEnd)) ^ SYNC_ACTIVE_LOW;
      ctl_d.vsync = ((y_d >= VsStart) && (y_d < VsEnd)) ^ SYNC_ACTIVE_LOW;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q           <= '0;
         y_q           <= '0;
         frame_count_q <= '0;
         run_q         <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         ctl_q         <= ctl_idle(SYNC_ACTIVE_LOW);
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         frame_count_q <= frame_count_d;
         run_q         <= 1'b1;
         line_start_q  <= (x_d == '0);
         frame_start_q <= (x_d == '0) && (y_d == '0);
         ctl_q         <= ctl_d;
      end
   end

   vga_delay_line #(
      .Width  ($bits(vga_ctl_t)),
      .Depth  (LEAD),
      .RstVal (ctl_idle(SYNC_ACTIVE_LOW))
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (ctl_q),
      .q_o   (ctl_dly)
   );

   assign pixel_x_o     = x_q;
   assign pixel_y_o     = y_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;
   assign frame_count_o = frame_count_q;
   assign de_o          = ctl_dly.de;
   assign hsync_o       = ctl_dly.hsync;
   assign vsync_o       = ctl_dly.vsync;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: four builds share one clock and reset, each checked
// every cycle against a raster model derived from elapsed clocks since reset.
module tb_vga_timing;

   typedef struct {
      int x, y, ls, fs, fc, de, hs, vs;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   k     = 0;
   bit   cmp_en = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   logic [9:0] d_x; logic [9:0] d_y; logic [7:0] d_fc;
   logic d_ls, d_fs, d_de, d_hs, d_vs;
   logic [6:0] m_x; logic [5:0] m_y; logic [7:0] m_fc;
   logic m_ls, m_fs, m_de, m_hs, m_vs;
   logic [2:0] s_x; logic [2:0] s_y; logic [7:0] s_fc;
   logic s_ls, s_fs, s_de, s_hs, s_vs;
   logic [2:0] t_x; logic [2:0] t_y; logic [7:0] t_fc;
   logic t_ls, t_fs, t_de, t_hs, t_vs;

   vga_timing u_def (
      .clk (clk), .rst_n (rst_n), .pixel_x_o (d_x), .pixel_y_o (d_y),
      .line_start_o (d_ls), .frame_start_o (d_fs), .frame_count_o (d_fc),
      .de_o (d_de), .hsync_o (d_hs), .vsync_o (d_vs)
   );

   vga_timing #(
      .H_PIXELS (64), .H_FRONT_PORCH (4), .H_SYNC_PULSE (12), .H_BACK_PORCH (8),
      .V_PIXELS (48), .V_FRONT_PORCH (2), .V_SYNC_PULSE (2), .V_BACK_PORCH (4),
      .SYNC_ACTIVE_LOW (1'b1), .LEAD (2)
   ) u_mid (
      .clk (clk), .rst_n (rst_n), .pixel_x_o (m_x), .pixel_y_o (m_y),
      .line_start_o (m_ls), .frame_start_o (m_fs), .frame_count_o (m_fc),
      .de_o (m_de), .hsync_o (m_hs), .vsync_o (m_vs)
   );

   vga_timing #(
      .H_PIXELS (4), .H_FRONT_PORCH (1), .H_SYNC_PULSE (1), .H_BACK_PORCH (1),
      .V_PIXELS (3), .V_FRONT_PORCH (1), .V_SYNC_PULSE (1), .V_BACK_PORCH (1),
      .SYNC_ACTIVE_LOW (1'b0), .LEAD (0)
   ) u_sml (
      .clk (clk), .rst_n (rst_n), .pixel_x_o (s_x), .pixel_y_o (s_y),
      .line_start_o (s_ls), .frame_start_o (s_fs), .frame_count_o (s_fc),
      .de_o (s_de), .hsync_o (s_hs), .vsync_o (s_vs)
   );

   vga_timing #(
      .H_PIXELS (4), .H_FRONT_PORCH (1), .H_SYNC_PULSE (1), .H_BACK_PORCH (1),
      .V_PIXELS (3), .V_FRONT_PORCH (1), .V_SYNC_PULSE (1), .V_BACK_PORCH (1),
      .SYNC_ACTIVE_LOW (1'b1), .LEAD (3)
   ) u_l3 (
      .clk (clk), .rst_n (rst_n), .pixel_x_o (t_x), .pixel_y_o (t_y),
      .line_start_o (t_ls), .frame_start_o (t_fs), .frame_count_o (t_fc),
      .de_o (t_de), .hsync_o (t_hs), .vsync_o (t_vs)
   );

   // k = clocks since reset release (0 while held); raster position is k-1.
   function automatic exp_t model(int kk, int hp, int hf, int hsp, int hb,
                                  int vp, int vf, int vsp, int vb, int sal, int lead);
      exp_t e;
      int ht = hp + hf + hsp + hb;
      int vt = vp + vf + vsp + vb;
      int p, q, qx, qy;
      e = '{x: 0, y: 0, ls: 0, fs: 0, fc: 0, de: 0, hs: sal, vs: sal};
      if (kk > 0) begin
         p    = kk - 1;
         e.x  = p % ht;
         e.y  = (p / ht) % vt;
         e.fc = (p / (ht * vt)) % 256;
         e.ls = (e.x == 0) ? 1 : 0;
         e.fs = (e.x == 0 && e.y == 0) ? 1 : 0;
         if (kk > lead) begin
            q    = p - lead;
            qx   = q % ht;
            qy   = (q / ht) % vt;
            e.de = (qx < hp && qy < vp) ? 1 : 0;
            e.hs = (qx >= hp + hf && qx < hp + hf + hsp) ? 1 - sal : sal;
            e.vs = (qy >= vp + vf && qy < vp + vf + vsp) ? 1 - sal : sal;
         end
      end
      return e;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s at k=%0d: got %0d, want %0d", name, k, got, want);
   endtask

   task automatic cmp_all(input string tag, input exp_t e, input int x, input int y,
                          input int ls, input int fs, input int fc, input int de,
                          input int hs, input int vs);
      chk({tag, ".pixel_x"}, x, e.x);
      chk({tag, ".pixel_y"}, y, e.y);
      chk({tag, ".line_start"}, ls, e.ls);
      chk({tag, ".frame_start"}, fs, e.fs);
      chk({tag, ".frame_count"}, fc, e.fc);
      chk({tag, ".de"}, de, e.de);
      chk({tag, ".hsync"}, hs, e.hs);
      chk({tag, ".vsync"}, vs, e.vs);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp_all("def", model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1),
                 d_x, d_y, d_ls, d_fs, d_fc, d_de, d_hs, d_vs);
         cmp_all("mid", model(k, 64, 4, 12, 8, 48, 2, 2, 4, 1, 2),
                 m_x, m_y, m_ls, m_fs, m_fc, m_de, m_hs, m_vs);
         cmp_all("sml", model(k, 4, 1, 1, 1, 3, 1, 1, 1, 0, 0),
                 s_x, s_y, s_ls, s_fs, s_fc, s_de, s_hs, s_vs);
         cmp_all("l3", model(k, 4, 1, 1, 1, 3, 1, 1, 1, 1, 3),
                 t_x, t_y, t_ls, t_fs, t_fc, t_de, t_hs, t_vs);
      end
   end

   int  hs_low_cnt = 0, vs_low_cnt = 0;
   int  ls_first = -1, ls_second = -1, fs_first = -1, fs_second = -1;
   bit  hs_prev = 1'b1, vs_prev = 1'b1, hs_seen = 1'b0, vs_seen = 1'b0, found = 1'b0;

   initial begin
      rst_n = 1'b0;
      @(negedge clk);
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.def.de", d_de, 0);
      chk("rst.def.hsync", d_hs, 1);
      chk("rst.sml.hsync", s_hs, 0);
      rst_n = 1'b1;

      for (int c = 1; c <= 10760; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("c1.def.pixel_x", d_x, 0);
            chk("c1.def.pixel_y", d_y, 0);
            chk("c1.def.line_start", d_ls, 1);
            chk("c1.def.frame_start", d_fs, 1);
            chk("c1.def.de", d_de, 0);
            chk("lead0.de_at_x0", s_de, 1);
         end
         if (c == 2) chk("c2.def.de", d_de, 1);
         if (c == 3) chk("lead3.de_before", t_de, 0);
         if (c == 4) begin
            chk("lead3.de_rise", t_de, 1);
            chk("lead3.pixel_x_at_rise", t_x, 3);
            chk("lead3.pixel_y_at_rise", t_y, 0);
         end
         if (c <= 800 && d_hs == 1'b0) hs_low_cnt++;
         if (!hs_seen && hs_prev && !d_hs) begin
            hs_seen = 1'b1;
            chk("def.hsync_fall_x", d_x, 657);
         end
         hs_prev = d_hs;
         if (d_ls && c <= 801) begin
            if (ls_first < 0) ls_first = c;
            else if (ls_second < 0) ls_second = c;
         end
         if (c == 800) chk("def.hsync_low_clocks", hs_low_cnt, 96);
         if (c <= 4928 && m_vs == 1'b0) vs_low_cnt++;
         if (!vs_seen && vs_prev && !m_vs) begin
            vs_seen = 1'b1;
            chk("mid.vsync_fall_y", m_y, 50);
            chk("mid.vsync_fall_x", m_x, 2);
         end
         vs_prev = m_vs;
         if (m_fs && c <= 4929) begin
            if (fs_first < 0) fs_first = c;
            else if (fs_second < 0) fs_second = c;
         end
         if (c == 4928) begin
            chk("mid.vsync_low_clocks", vs_low_cnt, 176);
            chk("mid.frame_count_pre", m_fc, 0);
         end
         if (c == 4929) chk("mid.frame_count_one", m_fc, 1);
         if (c == 10711) chk("sml.frame_count_255", s_fc, 255);
         if (c == 10752) chk("sml.frame_count_255_last", s_fc, 255);
         if (c == 10753) chk("sml.frame_count_wrap0", s_fc, 0);
      end
      chk("def.line_start_period", ls_second - ls_first, 800);
      chk("mid.frame_start_period", fs_second - fs_first, 4928);

      for (int i = 0; i < 6000 && !found; i++) begin
         @(negedge clk);
         if (m_x == 7'd40 && m_y == 6'd30) found = 1'b1;
      end
      chk("mid.reached_40_30", int'(found), 1);
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst.mid.pixel_x", m_x, 0);
         chk("rst.mid.pixel_y", m_y, 0);
         chk("rst.mid.line_start", m_ls, 0);
         chk("rst.mid.frame_start", m_fs, 0);
         chk("rst.mid.frame_count", m_fc, 0);
         chk("rst.mid.de", m_de, 0);
         chk("rst.mid.hsync", m_hs, 1);
         chk("rst.mid.vsync", m_vs, 1);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart.mid.pixel_x", m_x, 0);
      chk("restart.mid.pixel_y", m_y, 0);
      chk("restart.mid.line_start", m_ls, 1);
      chk("restart.mid.frame_start", m_fs, 1);
      chk("restart.mid.de", m_de, 0);
      repeat (200) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
